wait_event_detector: RTL and testbench
======================================

// Module: wait_event_detector
// PURPOSE
// Cycle-accurate wait-event engine for the testbench sequencer (WTR/WTF commands).
// Sits between the sequencer and the DUT observation bus:
//  - Sequencer side: takes a start request carrying signal index, edge type and timeout.
//  - DUT side: watches the selected lane of the wait bus.
//  - Result: one-cycle pulse for done, timeout or error, plus an elapsed-cycle count.
// PARAMETERS
// WAIT_SIZE      5   number of observable lanes on wait_signals
// WAIT_WIDTH     1   width of each lane; edge detection uses bit 0 of the lane
// TIMEOUT_WIDTH  32  width of max_timeout and elapsed
// PORTS
// clk           in   1                        testbench clock, rising-edge
// rst           in   1                        async active-high reset
// start         in   1                        1-cycle request; sampled only in IDLE
// wait_sel      in   $clog2(WAIT_SIZE)        lane index to watch
// sel_wtr_wtf   in   1                        1 = wait rising edge, 0 = wait falling edge
// max_timeout   in   TIMEOUT_WIDTH            timeout in clk cycles; 0 = no timeout
// abort         in   1                        cancel the current wait, no result pulse
// wait_signals  in   WAIT_SIZE*WAIT_WIDTH     flattened lanes; lane i = [i*WAIT_WIDTH +: WAIT_WIDTH]
// busy          out  1                        high in ARM and WAIT
// wait_done     out  1                        1-cycle pulse: requested edge seen
// wait_timeout  out  1                        1-cycle pulse: max_timeout elapsed with no edge
// wait_err      out  1                        1-cycle pulse: start with wait_sel >= WAIT_SIZE
// elapsed       out  TIMEOUT_WIDTH            WAIT cycles without the edge; held after the result
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE; busy, wait_done, wait_timeout, wait_err = 0; elapsed = 0.
// - Reset applied mid-wait: aborts silently; no result pulse after release.
// - FSM states: IDLE, ARM, WAIT.
// - IDLE, start=1, wait_sel < WAIT_SIZE:
//   - latch wait_sel, sel_wtr_wtf and max_timeout; clear elapsed; go to ARM next cycle.
// - IDLE, start=1, wait_sel >= WAIT_SIZE:
//   - pulse wait_err on the next cycle; stay in IDLE; elapsed is unchanged.
// - ARM (1 cycle): register bit 0 of the selected lane as prev; go to WAIT.
// - WAIT, each cycle, with cur = bit 0 of the selected lane:
//   - edge = sel ? (!prev & cur) : (prev & !cur); then prev <= cur.
//   - edge: pulse wait_done next cycle; elapsed holds; go to IDLE.
//   - else if max_timeout != 0 and elapsed+1 == max_timeout:
//     pulse wait_timeout next cycle; elapsed = max_timeout; go to IDLE.
//   - else: elapsed <= elapsed+1. On reaching the all-ones value, elapsed saturates (no wrap).
// - Simultaneous edge and timeout in the same cycle: edge wins; only wait_done pulses.
// - abort=1 in ARM or WAIT: go to IDLE next cycle; no pulse; elapsed holds.
// - abort in IDLE: no effect. abort has priority over edge and timeout in the same cycle.
// - start while busy: ignored; it is not queued.
// - Latency: start at cycle N, ARM at N+1, first edge compare at N+2.
//   An edge first visible at cycle N+2 gives wait_done=1 at N+3 with elapsed=0.
// - busy falls in the same cycle that the result pulse is high.
// - A new start is accepted in that same cycle.
// - Only one of wait_done, wait_timeout, wait_err is high in any cycle.
// - Latched config is stable for the whole wait; input changes during busy are ignored.
// TESTING
// 1) sel=1, lane 2, max_timeout=100; lane2 0->1 at 10 cycles after start
//    -> wait_done one pulse, elapsed=8, busy low afterwards.
// 2) sel=0, lane 0, max_timeout=5; lane held at 1
//    -> wait_timeout at start+7, elapsed=5, no wait_done.
// 3) max_timeout=3; falling edge lands on the 3rd WAIT cycle
//    -> wait_done only, elapsed=2 (edge beats timeout).
// 4) wait_sel=7 with WAIT_SIZE=5
//    -> wait_err pulse next cycle, busy stays 0; start during busy -> ignored.
// 5) abort at WAIT cycle 4, then rst pulse mid-wait on a second run
//    -> no result pulses, state IDLE, outputs at reset values.
// 6) max_timeout=0; edge after 1000 cycles
//    -> wait_done with elapsed=999; lane 1 toggling while lane 3 watched -> no reaction.

Source files
------------

// File: rtl/wait_event_detector.sv
// Wait-event engine: arms on a start request, watches bit 0 of one lane for a
// rising or falling edge, and reports done / timeout / error with elapsed cycles.
module wait_event_detector #(
    parameter int unsigned WAIT_SIZE     = 5,
    parameter int unsigned WAIT_WIDTH    = 1,
    parameter int unsigned TIMEOUT_WIDTH = 32,
    localparam int unsigned SEL_W = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1,
    localparam int unsigned BUS_W = WAIT_SIZE * WAIT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SEL_W-1:0]         wait_sel,
    input  logic                     sel_wtr_wtf,
    input  logic [TIMEOUT_WIDTH-1:0] max_timeout,
    input  logic                     abort,
    input  logic [BUS_W-1:0]         wait_signals,
    output logic                     busy,
    output logic                     wait_done,
    output logic                     wait_timeout,
    output logic                     wait_err,
    output logic [TIMEOUT_WIDTH-1:0] elapsed
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [SEL_W-1:0]         lane_q, lane_d;
    logic                     rise_q, rise_d;
    logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_d;
    logic [TIMEOUT_WIDTH-1:0] elapsed_q, elapsed_d;
    logic                     prev_q, prev_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     tmo_q, tmo_d;
    logic                     err_q, err_d;

    logic [WAIT_SIZE-1:0]     lane_bit0_c;
    logic                     cur_c;
    logic                     edge_hit_c;
    logic [TIMEOUT_WIDTH-1:0] elapsed_inc_c;

    // Edge detection only ever looks at bit 0 of each lane.
    always_comb begin
        for (int i = 0; i < int'(WAIT_SIZE); i++) begin
            lane_bit0_c[i] = wait_signals[i*int'(WAIT_WIDTH)];
        end
    end

    assign cur_c         = lane_bit0_c[lane_q];
    assign edge_hit_c    = rise_q ? (!prev_q && cur_c) : (prev_q && !cur_c);
    assign elapsed_inc_c = elapsed_q + TIMEOUT_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        rise_d    = rise_q;
        timeout_d = timeout_q;
        elapsed_d = elapsed_q;
        prev_d    = prev_q;
        done_d    = 1'b0;
        tmo_d     = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (32'(wait_sel) < WAIT_SIZE) begin
                        lane_d    = wait_sel;
                        rise_d    = sel_wtr_wtf;
                        timeout_d = max_timeout;
                        elapsed_d = '0;
                        state_d   = ST_ARM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    prev_d  = cur_c;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    prev_d = cur_c;
                    // Edge outranks a timeout landing in the same cycle.
                    if (edge_hit_c) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if ((timeout_q != '0) && (elapsed_inc_c == timeout_q)) begin
                        tmo_d     = 1'b1;
                        elapsed_d = timeout_q;
                        state_d   = ST_IDLE;
                    end else if (elapsed_q != '1) begin
                        elapsed_d = elapsed_inc_c;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lane_q    <= '0;
            rise_q    <= 1'b0;
            timeout_q <= '0;
            elapsed_q <= '0;
            prev_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            rise_q    <= rise_d;
            timeout_q <= timeout_d;
            elapsed_q <= elapsed_d;
            prev_q    <= prev_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    assign busy         = busy_q;
    assign wait_done    = done_q;
    assign wait_timeout = tmo_q;
    assign wait_err     = err_q;
    assign elapsed      = elapsed_q;

endmodule

// File: tb/tb_wait_event_detector.sv
// Directed bench for wait_event_detector: a vector table of single waits plus
// hand-written sequences for busy-start, abort, back-to-back and reset cases.
module tb_wait_event_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  wait_sel;
    logic        sel_wtr_wtf;
    logic [31:0] max_timeout;
    logic        abort;
    logic [4:0]  wait_signals;
    logic        busy;
    logic        wait_done;
    logic        wait_timeout;
    logic        wait_err;
    logic [31:0] elapsed;

    int n_chk  = 0;
    int n_fail = 0;

    // Pulse recorder state: kind is {done, timeout, err}.
    int          npulse;
    int          first_cyc;
    logic [2:0]  first_kind;
    logic [31:0] first_el;
    logic        first_busy;
    int          last_cyc;
    logic [2:0]  last_kind;
    logic [31:0] last_el;
    logic        busy_gap;

    typedef struct {
        logic [2:0]  lane;
        logic        rise;
        logic [31:0] tmo;
        logic        init;
        int          flip_at;
        logic        toggle1;
        int          exp_cyc;
        logic [2:0]  exp_kind;
        logic [31:0] exp_el;
    } vec_t;

    vec_t vecs[8];

    wait_event_detector #(
        .WAIT_SIZE(5), .WAIT_WIDTH(1), .TIMEOUT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wait_sel(wait_sel),
        .sel_wtr_wtf(sel_wtr_wtf), .max_timeout(max_timeout), .abort(abort),
        .wait_signals(wait_signals), .busy(busy), .wait_done(wait_done),
        .wait_timeout(wait_timeout), .wait_err(wait_err), .elapsed(elapsed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rec_clear();
        npulse     = 0;
        first_cyc  = 0;
        first_kind = '0;
        first_el   = '0;
        first_busy = 1'b0;
        last_cyc   = 0;
        last_kind  = '0;
        last_el    = '0;
        busy_gap   = 1'b0;
    endtask

    task automatic rec(input int c);
        logic [2:0] p;
        p = {wait_done, wait_timeout, wait_err};
        if (p != 3'b000) begin
            npulse++;
            if (first_cyc == 0) begin
                first_cyc  = c;
                first_kind = p;
                first_el   = elapsed;
                first_busy = busy;
            end
            last_cyc  = c;
            last_kind = p;
            last_el   = elapsed;
        end else if (first_cyc == 0 && !busy) begin
            busy_gap = 1'b1;
        end
    endtask

    task automatic begin_wait(input logic [2:0] lane, input logic rise, input logic [31:0] tmo);
        start       = 1'b1;
        wait_sel    = lane;
        sel_wtr_wtf = rise;
        max_timeout = tmo;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        string tag;
        v = vecs[idx];
        tag = $sformatf("v%0d", idx);
        rec_clear();
        wait_signals = '0;
        if (v.lane < 3'd5) wait_signals[v.lane] = v.init;
        begin_wait(v.lane, v.rise, v.tmo);
        for (int c = 1; c <= v.exp_cyc + 3; c++) begin
            step();
            if (c == 1) start = 1'b0;
            rec(c);
            if (c == v.flip_at) wait_signals[v.lane] = ~wait_signals[v.lane];
            if (v.toggle1) wait_signals[1] = ~wait_signals[1];
        end
        check({tag, "_cycle"}, 64'(first_cyc), 64'(v.exp_cyc));
        check({tag, "_kind"}, 64'(first_kind), 64'(v.exp_kind));
        check({tag, "_elapsed"}, 64'(first_el), 64'(v.exp_el));
        check({tag, "_npulse"}, 64'(npulse), 64'd1);
        check({tag, "_busy_at_result"}, 64'(first_busy), 64'd0);
        check({tag, "_busy_gap"}, 64'(busy_gap), 64'd0);
        step();
    endtask

    initial begin
        //          lane  rise  tmo     init  flip  tog   cyc   kind    el
        vecs[0] = '{3'd2, 1'b1, 32'd100, 1'b0, 10,   1'b0, 11,   3'b100, 32'd8};
        vecs[1] = '{3'd0, 1'b0, 32'd5,   1'b1, 0,    1'b0, 7,    3'b010, 32'd5};
        vecs[2] = '{3'd0, 1'b0, 32'd3,   1'b1, 4,    1'b0, 5,    3'b100, 32'd2};
        vecs[3] = '{3'd7, 1'b1, 32'd9,   1'b0, 0,    1'b0, 1,    3'b001, 32'd2};
        vecs[4] = '{3'd3, 1'b1, 32'd0,   1'b0, 1001, 1'b1, 1002, 3'b100, 32'd999};
        vecs[5] = '{3'd4, 1'b1, 32'd50,  1'b0, 2,    1'b0, 3,    3'b100, 32'd0};
        vecs[6] = '{3'd1, 1'b0, 32'd1,   1'b1, 0,    1'b0, 3,    3'b010, 32'd1};
        vecs[7] = '{3'd2, 1'b1, 32'd4,   1'b0, 1,    1'b0, 6,    3'b010, 32'd4};

        rst = 1'b1; start = 1'b0; wait_sel = '0; sel_wtr_wtf = 1'b0;
        max_timeout = '0; abort = 1'b0; wait_signals = '0;
        #1;
        check("reset_outputs", 64'({busy, wait_done, wait_timeout, wait_err}), 64'd0);
        check("reset_elapsed", 64'(elapsed), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(i);

        // Start while busy is ignored; original config governs the result.
        rec_clear();
        wait_signals = '0;
        begin_wait(3'd2, 1'b1, 32'd0);
        for (int c = 1; c <= 9; c++) begin
            step();
            rec(c);
            if (c == 1) start = 1'b0;
            if (c == 3) begin_wait(3'd7, 1'b1, 32'd0);
            if (c == 4) begin_wait(3'd0, 1'b0, 32'd1);
            if (c == 5) begin
                start = 1'b0;
                wait_signals[2] = 1'b1;
            end
        end
        check("busy_start_cycle", 64'(first_cyc), 64'd6);
        check("busy_start_kind", 64'(first_kind), 64'b100);
        check("busy_start_elapsed", 64'(first_el), 64'd3);
        check("busy_start_npulse", 64'(npulse), 64'd1);

        // Abort in the 4th WAIT cycle, coinciding with an edge: no pulse.
        rec_clear();
        wait_signals = '0;
        begin_wait(3'd2, 1'b1, 32'd0);
        for (int c = 1; c <= 12; c++) begin
            step();
            rec(c);
            if (c == 1) start = 1'b0;
            if (c == 5) begin
                abort = 1'b1;
                wait_signals[2] = 1'b1;
            end
            if (c == 6) begin
                abort = 1'b0;
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_elapsed", 64'(elapsed), 64'd3);
            end
            if (c == 8) wait_signals[2] = 1'b0;
            if (c == 9) wait_signals[2] = 1'b1;
        end
        check("abort_npulse", 64'(npulse), 64'd0);

        // Abort during ARM.
        rec_clear();
        wait_signals = '0;
        begin_wait(3'd1, 1'b1, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            step();
            rec(c);
            if (c == 1) begin
                start = 1'b0;
                abort = 1'b1;
            end
            if (c == 2) begin
                abort = 1'b0;
                check("abort_arm_busy", 64'(busy), 64'd0);
                check("abort_arm_elapsed", 64'(elapsed), 64'd0);
                wait_signals[1] = 1'b1;
            end
        end
        check("abort_arm_npulse", 64'(npulse), 64'd0);

        // Result cycle accepts a new start.
        rec_clear();
        wait_signals = '0;
        begin_wait(3'd0, 1'b1, 32'd0);
        for (int c = 1; c <= 8; c++) begin
            step();
            rec(c);
            if (c == 1) start = 1'b0;
            if (c == 2) wait_signals[0] = 1'b1;
            if (c == 3) begin_wait(3'd0, 1'b0, 32'd2);
            if (c == 4) begin
                start = 1'b0;
                check("b2b_busy", 64'(busy), 64'd1);
            end
        end
        check("b2b_first_cycle", 64'(first_cyc), 64'd3);
        check("b2b_first_kind", 64'(first_kind), 64'b100);
        check("b2b_last_cycle", 64'(last_cyc), 64'd7);
        check("b2b_last_kind", 64'(last_kind), 64'b010);
        check("b2b_last_elapsed", 64'(last_el), 64'd2);
        check("b2b_npulse", 64'(npulse), 64'd2);

        // Reset mid-wait aborts silently.
        rec_clear();
        wait_signals = '0;
        begin_wait(3'd2, 1'b1, 32'd0);
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) start = 1'b0;
            if (c == 4) begin
                rst = 1'b1;
                #1;
                check("midrst_outputs", 64'({busy, wait_done, wait_timeout, wait_err}), 64'd0);
                check("midrst_elapsed", 64'(elapsed), 64'd0);
            end
            if (c == 5) rst = 1'b0;
            if (c >= 5) rec(c);
            if (c == 6) wait_signals[2] = 1'b1;
        end
        check("midrst_npulse", 64'(npulse), 64'd0);
        check("midrst_busy_end", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
